// File: rtl/carbonz_sim_ctrl.sv
// carbonz_sim_ctrl: byte-wide simulation-control responder. It holds the completion
// signature and the keyed power-off, plus a cycle counter with snapshot and a sticky watchdog.
`timescale 1ns/1ps
module carbonz_sim_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [7:0]  KEY0           = 8'hA5,
    parameter logic [7:0]  KEY1           = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_ack,
    output logic [31:0] signature,
    output logic        poweroff,
    output logic        timeout
);

    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,
        KEY_ARMED = 2'd1,
        KEY_OFF   = 2'd2
    } key_state_t;

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam bit          WDOG_EN     = (TIMEOUT_CYCLES != 0);

    key_state_t  key_state;
    key_state_t  key_next;
    logic [31:0] cnt;
    logic [31:0] sat;
    logic [31:0] sat_next;
    logic [31:0] snap;
    logic [7:0]  rd_byte;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic        ctrl_wr;
    logic        po_rise;
    logic        run;

    // The ack cycle itself blocks acceptance, so a held request cannot re-enter early.
    assign accept   = bus_req & ~bus_ack;
    assign wr_en    = accept & bus_we;
    assign rd_en    = accept & ~bus_we;
    assign ctrl_wr  = wr_en & (bus_addr == 4'h4);
    assign poweroff = (key_state == KEY_OFF);
    assign run      = ~poweroff;
    assign sat_next = (sat == '1) ? sat : sat + 32'd1;

    always_comb begin
        key_next = key_state;
        po_rise  = 1'b0;
        case (key_state)
            KEY_IDLE: begin
                if (ctrl_wr) begin
                    key_next = (bus_wdata == KEY0) ? KEY_ARMED : KEY_IDLE;
                end
            end
            KEY_ARMED: begin
                if (ctrl_wr) begin
                    if (bus_wdata == KEY1) begin
                        key_next = KEY_OFF;
                        po_rise  = 1'b1;
                    end else if (bus_wdata == KEY0) begin
                        key_next = KEY_ARMED;
                    end else begin
                        key_next = KEY_IDLE;
                    end
                end
            end
            KEY_OFF:  key_next = KEY_OFF;
            default:  key_next = KEY_IDLE;
        endcase
    end

    always_comb begin
        rd_byte = '0;
        case (bus_addr)
            4'h0:    rd_byte = signature[7:0];
            4'h1:    rd_byte = signature[15:8];
            4'h2:    rd_byte = signature[23:16];
            4'h3:    rd_byte = signature[31:24];
            4'h5:    rd_byte = {5'b00000, timeout, (key_state == KEY_ARMED), poweroff};
            4'h8:    rd_byte = cnt[7:0];
            4'h9:    rd_byte = snap[15:8];
            4'hA:    rd_byte = snap[23:16];
            4'hB:    rd_byte = snap[31:24];
            default: rd_byte = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state <= KEY_IDLE;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            signature <= '0;
            timeout   <= 1'b0;
            cnt       <= '0;
            sat       <= '0;
            snap      <= '0;
        end else begin
            key_state <= key_next;
            bus_ack   <= accept;
            bus_rdata <= rd_en ? rd_byte : '0;

            if (run) begin
                cnt <= cnt + 32'd1;
                sat <= sat_next;
            end

            // Saturating copy keeps a counter wrap from re-matching; a same-edge power-off wins.
            if (WDOG_EN && run && !po_rise && (sat_next == TIMEOUT_LIM)) begin
                timeout <= 1'b1;
            end

            if (rd_en && (bus_addr == 4'h8)) begin
                snap <= cnt;
            end

            if (wr_en && !poweroff && (bus_addr[3:2] == 2'b00)) begin
                signature[{bus_addr[1:0], 3'b000} +: 8] <= bus_wdata;
            end
        end
    end

endmodule

// File: doc/carbonz_sim_ctrl.md
# carbonz_sim_ctrl

- Byte-wide memory-mapped simulation-control responder for the CarbonZ480 system.
- The CPU writes a 32-bit completion signature and a keyed power-off command through it.
- It drives the top-level `signature` and `poweroff` outputs that the system testbench samples to decide pass or fail.
- It also provides a free-running cycle counter with an atomic snapshot, and a sticky watchdog timeout flag.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 200000: cycles after reset release at which `timeout` sets if `poweroff` is still low. A value of 0 disables the watchdog.
- KEY0, default 8'hA5: first power-off key byte.
- KEY1, default 8'h5A: second power-off key byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- bus_req  in  1  access request; held high until `bus_ack`.
- bus_we  in  1  1 = write, 0 = read; stable while `bus_req` is high.
- bus_addr  in  4  register address; stable while `bus_req` is high.
- bus_wdata  in  8  write data; stable while `bus_req` is high.
- bus_rdata  out  8  read data; valid only in the cycle `bus_ack` is high, 0 otherwise.
- bus_ack  out  1  one-cycle completion pulse.
- signature  out  32  current SIG register.
- poweroff  out  1  sticky power-off request.
- timeout  out  1  sticky watchdog expiry.

## Operation
Register map (undefined addresses: writes ignored, reads return 0, access still acked):
- 0x0–0x3 SIG bytes 0–3, little-endian (0x0 = bits 7:0). R/W. Writes are ignored once `poweroff` = 1; reads always work.
- 0x4 CTRL (write-only, reads 0). Key state machine:
  - IDLE: write of KEY0 → ARMED; any other write → IDLE.
  - ARMED: write of KEY1 → OFF and `poweroff` set; write of KEY0 → ARMED; any other write → IDLE.
  - OFF: terminal until reset; all CTRL writes ignored.
  - Accesses to other addresses do not change key state.
- 0x5 STATUS (RO): bit0 = `poweroff`, bit1 = ARMED, bit2 = `timeout`, bits 7:3 = 0.
- 0x8 CNT0: a read returns counter bits 7:0 and, in the same cycle, latches the full 32-bit counter into SNAP.
- 0x9–0xB: read SNAP bytes 1–3. Writes are ignored.

Counter and watchdog:
- Counter is 32-bit, counts every cycle after reset release, and wraps 0xFFFF_FFFF → 0.
- The counter stops incrementing in the cycle after `poweroff` rises, so the final count is preserved.
- Watchdog compares against a saturating copy of the counter, so counter wrap cannot clear or retrigger it.
- `timeout` sets when count == TIMEOUT_CYCLES and `poweroff` is 0. If both occur in the same cycle, `poweroff` wins and `timeout` stays 0.

## Timing
- Reset values: `signature` = 0, `poweroff` = 0, `timeout` = 0, `bus_ack` = 0, `bus_rdata` = 0, key state IDLE, counter 0, SNAP 0.
- A request is accepted on a rising edge where `bus_req` = 1 and `bus_ack` = 0.
- `bus_ack` goes high on the next cycle, for exactly one cycle, so access latency is 1 cycle.
- Register updates from a write become visible in the same cycle as `bus_ack`.
- The cycle after `bus_ack` is never an acceptance cycle, even if `bus_req` is still high. Back-to-back accesses therefore complete at most every 2 cycles.
- `poweroff` rises in the `bus_ack` cycle of the KEY1 write.
- `bus_rdata` for a CNT0 read carries the counter value from the acceptance edge; SNAP holds that same 32-bit value.
- Reset asserted mid-access: the pending ack is dropped, all state returns to reset values, and the master must re-issue the access.

## Test plan
- Reset, then write 0x5A, 0x34, 0x38, 0x30 to 0x0–0x3 → `signature` = 32'h3038_345A; each write gets a single-cycle ack exactly 1 cycle after acceptance.
- Write 0xA5, then 0x5A, to 0x4 → `poweroff` = 1 in the second ack cycle. A subsequent write 0xFF to 0x0 leaves `signature` unchanged. STATUS reads 8'h01.
- Key abort: write 0xA5, 0x00, 0x5A to 0x4 → `poweroff` stays 0. Write 0xA5, 0xA5, 0x5A → `poweroff` = 1.
- Snapshot: read 0x8 at counter value C, then read 0x9–0xB several cycles later → the four bytes reassemble to C, not the live count. Also force the counter to 0xFFFF_FFFE and check it wraps to 0.
- Watchdog with TIMEOUT_CYCLES = 50 and no power-off → `timeout` = 1 at count 50 and stays set; STATUS bit2 = 1. A later power-off leaves `timeout` = 1.
- Assert `rst` one cycle after a write request is accepted → no ack, all outputs 0. The re-issued write completes normally.
